// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition RAM reader.
package acq_pkg;

  localparam int ACQ_ADDR_W = 12;
  localparam int ACQ_DATA_W = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } acq_state_t;

endpackage

// File: rtl/acq_skid_fifo.sv
// Shift-register output FIFO: entry 0 is always the head, so the head
// data and valid come straight from flops.
module acq_skid_fifo
  import acq_pkg::*;
#(
  parameter int W = ACQ_DATA_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [W-1:0]          i_data,
  input  logic                  i_pop,
  output logic [W-1:0]          o_data,
  output logic                  o_valid,
  output logic [FIFO_CNT_W-1:0] o_count
);

  logic [W-1:0]          r_mem [FIFO_DEPTH];
  logic [W-1:0]          w_mem_next [FIFO_DEPTH];
  logic [FIFO_CNT_W-1:0] r_count;
  logic [FIFO_CNT_W-1:0] w_count_next;
  logic [FIFO_CNT_W-1:0] w_wr_idx;
  logic                  r_valid;
  logic                  w_pop;

  assign w_pop = i_pop & r_valid;

  // A push lands behind the last surviving entry, i.e. after any pop shift.
  always_comb begin
    w_wr_idx     = r_count - FIFO_CNT_W'(w_pop);
    w_count_next = r_count + FIFO_CNT_W'(i_push) - FIFO_CNT_W'(w_pop);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_mem_next[i] = r_mem[i];
    end
    if (w_pop) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        w_mem_next[i] = r_mem[i+1];
      end
    end
    if (i_push) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (FIFO_CNT_W'(i) == w_wr_idx) begin
          w_mem_next[i] = i_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= w_mem_next[i];
      end
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
    end
  end

  assign o_data  = r_mem[0];
  assign o_valid = r_valid;
  assign o_count = r_count;

endmodule

// File: rtl/acq_ram_reader.sv
// Reads a block of words from a 1-cycle-latency sample RAM and streams them
// out. Stream handshake: a word moves on a cycle where m_valid and m_ready
// are both high; once m_valid rises, m_data/m_last hold until that happens.
module acq_ram_reader
  import acq_pkg::*;
#(
  parameter int ADDR_W = ACQ_ADDR_W,
  parameter int DATA_W = ACQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output acq_state_t        dbg_state
);

  localparam logic [FIFO_CNT_W:0] OCC_LIMIT = (FIFO_CNT_W+1)'(FIFO_DEPTH);

  acq_state_t            r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_rd_en;
  logic [ADDR_W-1:0]     r_rd_addr;
  logic                  r_rd_last;
  logic                  r_pend;
  logic                  r_pend_last;
  logic [ADDR_W:0]       r_left;

  logic [DATA_W:0]       w_head;
  logic                  w_fifo_valid;
  logic [FIFO_CNT_W-1:0] w_fifo_count;
  logic [FIFO_CNT_W-1:0] w_cnt_next;
  logic [FIFO_CNT_W:0]   w_occ;
  logic                  w_can_issue;
  logic                  w_pop;

  assign w_pop = w_fifo_valid & m_ready;

  // Words buffered after this edge plus the read still on the RAM bus must
  // leave room for one more, so a new read can never overflow the FIFO.
  assign w_cnt_next  = w_fifo_count + FIFO_CNT_W'(r_pend) - FIFO_CNT_W'(w_pop);
  assign w_occ       = {1'b0, w_cnt_next} + (FIFO_CNT_W+1)'(r_rd_en);
  assign w_can_issue = (w_occ < OCC_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_last   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_left      <= '0;
    end else begin
      r_done      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_pend      <= r_rd_en;
      r_pend_last <= r_rd_en & r_rd_last;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state   <= ST_READ;
              r_busy    <= 1'b1;
              r_rd_en   <= 1'b1;
              r_rd_addr <= start_addr;
              r_rd_last <= (len == (ADDR_W+1)'(1));
              r_left    <= len - (ADDR_W+1)'(1);
            end
          end
        end
        ST_READ: begin
          if (r_left == '0) begin
            r_state <= ST_DRAIN;
          end else if (w_can_issue) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
            r_rd_last <= (r_left == (ADDR_W+1)'(1));
            r_left    <= r_left - (ADDR_W+1)'(1);
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_head[DATA_W]) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  acq_skid_fifo #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_pend),
    .i_data ({r_pend_last, ram_rd_data}),
    .i_pop  (m_ready),
    .o_data (w_head),
    .o_valid(w_fifo_valid),
    .o_count(w_fifo_count)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign ram_rd_en   = r_rd_en;
  assign ram_rd_addr = r_rd_addr;
  assign m_data      = w_head[DATA_W-1:0];
  assign m_valid     = w_fifo_valid;
  assign m_last      = w_fifo_valid & w_head[DATA_W];
  assign dbg_state   = r_state;

endmodule

// File: doc/acq_ram_reader.md
ACQ_RAM_READER -- requirements
Module: acq_ram_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning the sample RAM address width (buffer depth 2^ADDR_W words).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the sample word width.
REQ-003 clk  in  1  The single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  in  1  Reset, synchronous and active-high.
REQ-005 start  in  1  Readout request, sampled in IDLE only.
REQ-006 start_addr  in  ADDR_W  First RAM address to read.
REQ-007 len  in  ADDR_W+1  Number of words to read, 0..2^ADDR_W.
REQ-008 busy  out  1  High from the accepted start until the done pulse.
REQ-009 done  out  1  One-cycle completion pulse.
REQ-010 ram_rd_en  out  1  RAM read strobe.
REQ-011 ram_rd_addr  out  ADDR_W  RAM read address.
REQ-012 ram_rd_data  in  DATA_W  RAM read data, valid exactly 1 cycle after ram_rd_en.
REQ-013 m_data  out  DATA_W  Output stream data.
REQ-014 m_valid  out  1  Output stream valid.
REQ-015 m_ready  in  1  Output stream ready (backpressure).
REQ-016 m_last  out  1  Marks the final word of a readout.

Function
REQ-017 The FSM SHALL have states IDLE, READ and DRAIN. Transitions: IDLE->READ on start with len>0; READ->DRAIN when the last read is issued; DRAIN->IDLE on the handshake of the m_last word.
REQ-018 Start with len=0 SHALL issue no reads, SHALL pulse done in the following cycle, and SHALL leave the FSM in IDLE.
REQ-019 start while busy=1 SHALL be ignored; start_addr and len SHALL be captured only on acceptance.
REQ-020 The first ram_rd_en SHALL assert in the cycle after start is sampled, with ram_rd_addr=start_addr.
REQ-021 Each subsequent read SHALL use the previous address +1, wrapping from 2^ADDR_W-1 to 0.
REQ-022 Exactly len reads SHALL be issued per readout.
REQ-023 Returned data SHALL be written into a 4-entry output FIFO.
REQ-024 A read SHALL be issued only when FIFO occupancy plus in-flight reads is less than 4, so the FIFO never overflows.
REQ-025 The first m_valid SHALL rise 3 cycles after the start cycle.
REQ-026 With m_ready held high, the block SHALL sustain 1 word per cycle.
REQ-027 A word SHALL transfer when m_valid and m_ready are both 1.
REQ-028 While m_valid=1 and m_ready=0, m_data, m_valid and m_last SHALL hold stable.
REQ-029 A simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-030 m_last SHALL be 1 only with the len-th word.
REQ-031 done SHALL pulse in the cycle after the m_last handshake, and busy SHALL fall in the same cycle.

Reset
REQ-032 While rst=1 the FSM SHALL go to IDLE, the FIFO and in-flight count SHALL be flushed, and busy, done, ram_rd_en, m_valid and m_last SHALL be 0.
REQ-033 While rst=1, ram_rd_addr and m_data SHALL be 0.
REQ-034 Reset asserted mid-readout SHALL abort the readout without a done pulse, and read data returning in the cycle after reset SHALL be discarded.

Structure
REQ-035 A shared package acq_pkg SHALL hold the FSM state enum, the FIFO depth constant (4) and the ADDR_W/DATA_W defaults.
REQ-036 The output FIFO SHALL be a sub-module acq_skid_fifo (4 entries, push/pop/count, registered head output).

Verification
REQ-037 Basic readout: start_addr=0x010, len=4, m_ready=1 -> reads at 0x010..0x013 from cycle 1; m_data = RAM[0x010..0x013] on 4 consecutive cycles from cycle 3; m_last on the 4th word; done one cycle later.
REQ-038 Address wrap: start_addr=0xFFE, len=4 -> read addresses 0xFFE, 0xFFF, 0x000, 0x001 in that order.
REQ-039 Backpressure: len=8 with m_ready toggling 1,0,0,1,... -> all 8 words delivered in order with no loss or duplication, outputs stable while stalled, at most 4 reads outstanding-or-buffered.
REQ-040 Zero length and busy start: len=0 -> done pulse, no ram_rd_en; start pulsed during a len=16 readout -> ignored, exactly 16 words delivered.
REQ-041 Reset mid-op: rst for 1 cycle after the 5th word of len=16 -> outputs 0 next cycle, no done; a new start_addr=0x100, len=2 readout then completes correctly.
REQ-042 Full buffer: len=4096, start_addr=0 -> 4096 words, m_last on RAM[0xFFF], a single done pulse.
